// File: rtl/display_scheduler.sv
// ---------------------------------------------------------------------------
// display_scheduler
//
// Chooses what the 4-digit vending-machine display shows. Normally it tracks
// the inserted credit. Short-lived messages (selected price, change owed,
// error) take over the display for HOLD_CYCLES cycles and then fall back to
// credit. A message can be replaced by an event of equal or higher priority
// (ERROR > CHANGE > PRICE > CREDIT), but never by a lower-priority one.
// While ERROR is shown, disp_blank toggles every BLINK_CYCLES cycles so the
// "Err" text blinks.
//
// Event interface: sel_valid, vend_done and err are single-cycle pulses with
// no back-pressure. Their data (price, change) is valid only in the pulse
// cycle and is sampled on that rising edge. A pulse that loses arbitration
// or is outranked by the current message is dropped. It is not queued.
//
// Ports
//   clk        in   1   system clock, rising edge
//   reset      in   1   synchronous, active-high
//   credit     in   12  current inserted money (binary)
//   sel_valid  in   1   pulse: item selected, price valid
//   price      in   12  price of selected item
//   vend_done  in   1   pulse: item dispensed, change valid
//   change     in   12  change owed
//   err        in   1   pulse: insufficient credit or sold out
//   disp_value out  12  binary value to show
//   disp_err   out  1   show "Err" instead of digits
//   disp_blank out  1   blank all digits
//   mode       out  2   current state: 0 CREDIT, 1 PRICE, 2 CHANGE, 3 ERROR
//                       (this is also the FSM state for debug visibility)
// ---------------------------------------------------------------------------
module display_scheduler #(
  parameter int HOLD_CYCLES  = 100000000,
  parameter int BLINK_CYCLES = 25000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] credit,
  input  logic        sel_valid,
  input  logic [11:0] price,
  input  logic        vend_done,
  input  logic [11:0] change,
  input  logic        err,
  output logic [11:0] disp_value,
  output logic        disp_err,
  output logic        disp_blank,
  output logic [1:0]  mode
);

  // Counter widths. A parameter of 1 would give a zero-width counter, so
  // clamp to at least one bit.
  localparam int HW = (HOLD_CYCLES  > 1) ? $clog2(HOLD_CYCLES)  : 1;
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_RELOAD  = HW'(HOLD_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_RELOAD = BW'(BLINK_CYCLES - 1);

  // The encoding doubles as the priority level, so a plain magnitude
  // compare decides whether an event may take over the display.
  typedef enum logic [1:0] {
    ST_CREDIT = 2'd0,
    ST_PRICE  = 2'd1,
    ST_CHANGE = 2'd2,
    ST_ERROR  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [11:0]   value_q, value_d;
  logic          err_q, err_d;
  logic          blank_q, blank_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [BW-1:0] blink_q, blink_d;

  // Same-cycle arbitration: err > vend_done > sel_valid.
  logic        ev_valid;
  state_t      ev_state;
  logic [11:0] ev_value;
  logic        take;

  always_comb begin
    ev_valid = 1'b1;
    ev_state = ST_CREDIT;
    ev_value = 12'd0;
    if (err) begin
      ev_state = ST_ERROR;
      ev_value = 12'd0;
    end else if (vend_done) begin
      ev_state = ST_CHANGE;
      ev_value = change;
    end else if (sel_valid) begin
      ev_state = ST_PRICE;
      ev_value = price;
    end else begin
      ev_valid = 1'b0;
    end
    take = ev_valid && (ev_state >= state_q);
  end

  always_comb begin
    state_d = state_q;
    value_d = value_q;
    err_d   = err_q;
    blank_d = blank_q;
    hold_d  = hold_q;
    blink_d = blink_q;

    if (take) begin
      // Entry or re-entry: latch the message and restart both timers.
      state_d = ev_state;
      value_d = ev_value;
      err_d   = (ev_state == ST_ERROR);
      blank_d = 1'b0;
      hold_d  = HOLD_RELOAD;
      blink_d = BLINK_RELOAD;
    end else if (state_q == ST_CREDIT) begin
      value_d = credit;
    end else if (hold_q == '0) begin
      // Message has been shown for its full hold time.
      state_d = ST_CREDIT;
      value_d = credit;
      err_d   = 1'b0;
      blank_d = 1'b0;
      blink_d = '0;
    end else begin
      hold_d = hold_q - 1'b1;
      if (state_q == ST_ERROR) begin
        if (blink_q == '0) begin
          blank_d = ~blank_q;
          blink_d = BLINK_RELOAD;
        end else begin
          blink_d = blink_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_CREDIT;
      value_q <= 12'd0;
      err_q   <= 1'b0;
      blank_q <= 1'b0;
      hold_q  <= '0;
      blink_q <= '0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      err_q   <= err_d;
      blank_q <= blank_d;
      hold_q  <= hold_d;
      blink_q <= blink_d;
    end
  end

  assign disp_value = value_q;
  assign disp_err   = err_q;
  assign disp_blank = blank_q;
  assign mode       = state_q;

endmodule

// File: tb/tb_display_scheduler.sv
// ---------------------------------------------------------------------------
// tb_display_scheduler
//
// Directed bench for display_scheduler with HOLD_CYCLES=10, BLINK_CYCLES=3.
// A table of {inputs, expected outputs} rows covers credit tracking, price
// and change messages, priority filtering and reset. Hand-written sequences
// cover the blink pattern, error re-entry, events arriving exactly when the
// hold counter expires, and reset in the middle of a message.
// Inputs are driven 1 ns after a rising edge. Outputs are checked 1 ns after
// the next rising edge.
// ---------------------------------------------------------------------------
module tb_display_scheduler;

  localparam int HOLD  = 10;
  localparam int BLINK = 3;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] credit;
  logic        sel_valid;
  logic [11:0] price;
  logic        vend_done;
  logic [11:0] change;
  logic        err;
  logic [11:0] disp_value;
  logic        disp_err;
  logic        disp_blank;
  logic [1:0]  mode;

  always #5 clk = ~clk;

  display_scheduler #(
    .HOLD_CYCLES (HOLD),
    .BLINK_CYCLES(BLINK)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .credit    (credit),
    .sel_valid (sel_valid),
    .price     (price),
    .vend_done (vend_done),
    .change    (change),
    .err       (err),
    .disp_value(disp_value),
    .disp_err  (disp_err),
    .disp_blank(disp_blank),
    .mode      (mode)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string name, input logic [11:0] e_val, input logic e_err,
                           input logic e_blank, input logic [1:0] e_mode);
    check({name, ".value"}, disp_value, e_val);
    check({name, ".err"},   {11'd0, disp_err},   {11'd0, e_err});
    check({name, ".blank"}, {11'd0, disp_blank}, {11'd0, e_blank});
    check({name, ".mode"},  {10'd0, mode},       {10'd0, e_mode});
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic rst, input logic [11:0] cr, input logic sel,
                       input logic [11:0] pr, input logic vd, input logic [11:0] ch,
                       input logic er);
    reset     = rst;
    credit    = cr;
    sel_valid = sel;
    price     = pr;
    vend_done = vd;
    change    = ch;
    err       = er;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic [11:0] cr;
    logic        sel;
    logic [11:0] pr;
    logic        vd;
    logic [11:0] ch;
    logic        er;
    logic [11:0] e_val;
    logic        e_err;
    logic        e_blank;
    logic [1:0]  e_mode;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic [11:0] cr, input logic sel,
                              input logic [11:0] pr, input logic vd, input logic [11:0] ch,
                              input logic er, input logic [11:0] e_val, input logic e_err,
                              input logic e_blank, input logic [1:0] e_mode);
    vec_t v;
    v.rst = rst; v.cr = cr; v.sel = sel; v.pr = pr; v.vd = vd; v.ch = ch; v.er = er;
    v.e_val = e_val; v.e_err = e_err; v.e_blank = e_blank; v.e_mode = e_mode;
    return v;
  endfunction

  initial begin
    drive(1'b1, 12'd0, 1'b0, 12'd0, 1'b0, 12'd0, 1'b0);

    // Reset, then credit tracking with one cycle of delay.
    vecs.push_back(mk(1, 150, 0, 0, 0, 0, 0,   0, 0, 0, 0));
    vecs.push_back(mk(0, 150, 0, 0, 0, 0, 0, 150, 0, 0, 0));
    vecs.push_back(mk(0, 200, 0, 0, 0, 0, 0, 200, 0, 0, 0));
    // Price message shown exactly 10 cycles.
    vecs.push_back(mk(0, 200, 1, 75, 0, 0, 0, 75, 0, 0, 1));
    for (int i = 0; i < HOLD - 1; i++)
      vecs.push_back(mk(0, 200, 0, 0, 0, 0, 0, 75, 0, 0, 1));
    vecs.push_back(mk(0, 210, 0, 0, 0, 0, 0, 210, 0, 0, 0));
    // PRICE -> CHANGE, then a lower-priority select is ignored (no reload).
    vecs.push_back(mk(0, 210, 1, 75, 0, 0, 0, 75, 0, 0, 1));
    vecs.push_back(mk(0, 210, 0, 0, 0, 0, 0, 75, 0, 0, 1));
    vecs.push_back(mk(0, 210, 0, 0, 1, 25, 0, 25, 0, 0, 2));
    vecs.push_back(mk(0, 210, 1, 99, 0, 0, 0, 25, 0, 0, 2));
    for (int i = 0; i < HOLD - 2; i++)
      vecs.push_back(mk(0, 210, 0, 0, 0, 0, 0, 25, 0, 0, 2));
    vecs.push_back(mk(0, 220, 0, 0, 0, 0, 0, 220, 0, 0, 0));
    // Reset overrides a simultaneous err.
    vecs.push_back(mk(1, 220, 0, 0, 0, 0, 1,   0, 0, 0, 0));
    vecs.push_back(mk(0, 230, 0, 0, 0, 0, 0, 230, 0, 0, 0));
    // vend_done straight from CREDIT, then err over CHANGE, lower vend ignored.
    vecs.push_back(mk(0, 230, 0, 0, 1, 40, 0, 40, 0, 0, 2));
    vecs.push_back(mk(0, 230, 0, 0, 0, 0, 1,  0, 1, 0, 3));
    vecs.push_back(mk(0, 230, 0, 0, 1, 60, 0,  0, 1, 0, 3));
    // Reset aborts ERROR.
    vecs.push_back(mk(1, 230, 0, 0, 0, 0, 0,   0, 0, 0, 0));
    vecs.push_back(mk(0, 240, 0, 0, 0, 0, 0, 240, 0, 0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].cr, vecs[i].sel, vecs[i].pr, vecs[i].vd, vecs[i].ch, vecs[i].er);
      step();
      check_out($sformatf("vec%0d", i), vecs[i].e_val, vecs[i].e_err, vecs[i].e_blank, vecs[i].e_mode);
    end

    // ---- all three pulses together: err wins, blink 0,0,0,1,1,1,0,0,0,1 ----
    for (int i = 0; i < HOLD; i++) begin
      if (i == 0) drive(0, 300, 1, 11, 1, 22, 1);
      else        drive(0, 300, 0, 0, 0, 0, 0);
      step();
      check_out($sformatf("blink%0d", i), 12'd0, 1'b1, 1'(((i / BLINK) % 2)), 2'd3);
    end
    drive(0, 301, 0, 0, 0, 0, 0);
    step();
    check_out("blink_exit", 12'd301, 1'b0, 1'b0, 2'd0);

    // ---- err re-entry five cycles into ERROR restarts hold and blink ----
    for (int i = 0; i < 5; i++) begin
      drive(0, 310, 0, 0, 0, 0, (i == 0));
      step();
      check_out($sformatf("reerr_a%0d", i), 12'd0, 1'b1, 1'(((i / BLINK) % 2)), 2'd3);
    end
    for (int i = 0; i < HOLD; i++) begin
      drive(0, 310, 0, 0, 0, 0, (i == 0));
      step();
      check_out($sformatf("reerr_b%0d", i), 12'd0, 1'b1, 1'(((i / BLINK) % 2)), 2'd3);
    end
    drive(0, 311, 0, 0, 0, 0, 0);
    step();
    check_out("reerr_exit", 12'd311, 1'b0, 1'b0, 2'd0);

    // ---- qualifying event exactly when hold reaches 0 wins ----
    for (int i = 0; i < HOLD; i++) begin
      drive(0, 320, (i == 0), 12'd77, 0, 0, 0);
      step();
      check_out($sformatf("edge_pr%0d", i), 12'd77, 1'b0, 1'b0, 2'd1);
    end
    drive(0, 320, 0, 0, 1, 12'd33, 0);
    step();
    check_out("edge_vend", 12'd33, 1'b0, 1'b0, 2'd2);
    for (int i = 1; i < HOLD; i++) begin
      drive(0, 320, 0, 0, 0, 0, 0);
      step();
      check_out($sformatf("edge_ch%0d", i), 12'd33, 1'b0, 1'b0, 2'd2);
    end
    // Lower-priority select at expiry does not hold the message.
    drive(0, 325, 1, 12'd88, 0, 0, 0);
    step();
    check_out("edge_low", 12'd325, 1'b0, 1'b0, 2'd0);

    // ---- reset during CHANGE ----
    drive(0, 330, 0, 0, 1, 12'd44, 0);
    step();
    check_out("rst_ch0", 12'd44, 1'b0, 1'b0, 2'd2);
    drive(0, 330, 0, 0, 0, 0, 0);
    step();
    check_out("rst_ch1", 12'd44, 1'b0, 1'b0, 2'd2);
    drive(1, 330, 0, 0, 0, 0, 0);
    step();
    check_out("rst_ch_rst", 12'd0, 1'b0, 1'b0, 2'd0);
    drive(0, 321, 0, 0, 0, 0, 0);
    step();
    check_out("rst_ch_rel", 12'd321, 1'b0, 1'b0, 2'd0);

    // ---- final report ----
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/display_scheduler.md
DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 100000000, cycles a message state stays on the 4-digit display (1 s at 100 MHz).
REQ-002 SHALL have parameter BLINK_CYCLES, default 25000000, half-period of the error blink.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port credit  input  12  current inserted money, binary.
REQ-006 SHALL have port sel_valid  input  1  one-cycle pulse: item selected, price valid.
REQ-007 SHALL have port price  input  12  price of selected item, sampled when sel_valid=1.
REQ-008 SHALL have port vend_done  input  1  one-cycle pulse: item dispensed, change valid.
REQ-009 SHALL have port change  input  12  change owed, sampled when vend_done=1.
REQ-010 SHALL have port err  input  1  one-cycle pulse: insufficient credit or sold out.
REQ-011 SHALL have port disp_value  output  12  binary value for the BCD converter and 7-segment driver.
REQ-012 SHALL have port disp_err  output  1  driver shows "Err" instead of digits.
REQ-013 SHALL have port disp_blank  output  1  driver blanks all digits.
REQ-014 SHALL have port mode  output  2  current state: 0 CREDIT, 1 PRICE, 2 CHANGE, 3 ERROR.

Function
REQ-015 SHALL implement four states: CREDIT (default), PRICE, CHANGE, ERROR; all outputs registered.
REQ-016 In CREDIT, disp_value SHALL equal credit delayed by one cycle; disp_err=0; disp_blank=0.
REQ-017 Priority on the same-cycle event: err > vend_done > sel_valid; only the winning event is acted on, the others are dropped.
REQ-018 Priority levels: ERROR 3, CHANGE 2, PRICE 1, CREDIT 0.
REQ-019 An event whose level is >= the current state's level SHALL enter its state, latch its value, and reload the hold counter to HOLD_CYCLES-1, with outputs changing one cycle after the pulse.
REQ-020 An event whose level is lower than the current state's level SHALL be ignored, with no latch and no counter reload.
REQ-021 Latched values: PRICE shows price, CHANGE shows change, ERROR shows disp_value=0 with disp_err=1.
REQ-022 The hold counter SHALL decrement once per cycle in PRICE/CHANGE/ERROR; at 0 with no qualifying event, the next state SHALL be CREDIT, so each message is shown for exactly HOLD_CYCLES cycles.
REQ-023 A qualifying event in the same cycle the counter reaches 0 SHALL win over the return to CREDIT.
REQ-024 In ERROR, disp_blank SHALL start at 0 on entry and toggle every BLINK_CYCLES cycles.
REQ-025 The blink counter SHALL restart on every ERROR entry or re-entry.
REQ-026 Outside ERROR, disp_blank SHALL be 0.
REQ-027 mode SHALL always reflect the state whose data is on disp_value in the same cycle.
REQ-028 Counters SHALL be sized ceil(log2(param)) bits and SHALL never wrap: hold stops at 0, blink reloads at BLINK_CYCLES-1.

Reset
REQ-029 reset=1 at a clock edge SHALL force state CREDIT, disp_value=0, disp_err=0, disp_blank=0, mode=0, and clear both counters; this overrides any simultaneous event.
REQ-030 Reset asserted mid-message SHALL abort the message immediately; after release, CREDIT tracking resumes on the next cycle.

Verification (HOLD_CYCLES=10, BLINK_CYCLES=3)
REQ-031 Reset, then credit=150 -> one cycle later disp_value=150, mode=0, disp_err=0, disp_blank=0.
REQ-032 sel_valid with price=75 -> next cycle mode=1 and disp_value=75 for exactly 10 cycles; it then returns to mode=0 showing current credit.
REQ-033 In PRICE, vend_done with change=25 -> mode=2, disp_value=25, hold restarts. In CHANGE, sel_valid -> ignored, mode stays 2.
REQ-034 err, vend_done and sel_valid pulsed together -> mode=3, disp_err=1; disp_blank follows the sequence 0,0,0,1,1,1,0... for 10 cycles, then mode=0.
REQ-035 Second err pulse 5 cycles into ERROR -> hold and blink counters restart, disp_blank=0, and ERROR lasts 10 further cycles.
REQ-036 Reset during CHANGE -> next cycle mode=0, disp_value=0; one cycle after release, disp_value=credit.
